ika87ad_mcseq: RTL
==================

IKA87AD_MCSEQ -- requirements
Module: ika87ad_mcseq

Interface
REQ-001 SHALL have i_CLK  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have i_RST  in  1  synchronous, active-high reset.
REQ-003 SHALL have i_CEN  in  1  cycle enable; the FSM and all registers advance only on edges where i_CEN=1.
REQ-004 SHALL have i_OPCODE_VALID  in  1  decoder offers a microcode entry point.
REQ-005 SHALL have i_OPCODE_ADDR  in  8  entry-point microcode address.
REQ-006 SHALL have i_BUS_ACK  in  1  bus cycle complete; releases BWAIT.
REQ-007 SHALL have i_MC_DATA  in  18  microcode word from ROM, valid on the clock after a read tick.
REQ-008 SHALL have o_MCROM_READ_TICK  out  1  ROM read strobe.
REQ-009 SHALL have o_MCROM_ADDR  out  8  ROM address.
REQ-010 SHALL have o_MC_WORD  out  18  captured microcode word for the execution stage.
REQ-011 SHALL have o_MC_VALID  out  1  one-clock pulse when o_MC_WORD is updated.
REQ-012 SHALL have o_OPCODE_REQ  out  1  high in IDLE; sequencer accepts an entry point.
REQ-013 SHALL have o_END  out  1  one-clock end-of-instruction pulse; o_END_RD4 out 1 qualifies it (0=RD3, 1=RD4).

Function
REQ-014 SHALL implement states IDLE, ISSUE, FETCH, BWAIT.
REQ-015 IDLE: o_OPCODE_REQ=1; on i_CEN & i_OPCODE_VALID, SHALL latch i_OPCODE_ADDR into address register, go ISSUE.
REQ-016 ISSUE: o_MCROM_READ_TICK SHALL equal i_CEN (exactly one i_CLK high per micro-step); o_MCROM_ADDR = address register; on i_CEN go FETCH.
REQ-017 FETCH on i_CEN: SHALL load o_MC_WORD<=i_MC_DATA, pulse o_MC_VALID for that clock, decode seq field i_MC_DATA[1:0].
REQ-018 Seq 2'b00 CONT: address<=address+1, go ISSUE.
REQ-019 Seq 2'b01 WAIT: address<=address+1, go BWAIT.
REQ-020 Seq 2'b10 RD3 / 2'b11 RD4: go IDLE, pulse o_END with o_END_RD4=i_MC_DATA[0], address unchanged.
REQ-021 BWAIT: on i_CEN & i_BUS_ACK go ISSUE; i_BUS_ACK outside BWAIT SHALL be ignored.
REQ-022 Address increment SHALL be 8-bit modulo: 8'hFF+1 = 8'h00, no flag.
REQ-023 i_OPCODE_VALID outside IDLE SHALL be ignored; entry point not queued.
REQ-024 With i_CEN=0 all outputs SHALL hold, except o_MCROM_READ_TICK, o_MC_VALID, o_END, which SHALL be 0.
REQ-025 An end in FETCH and an i_OPCODE_VALID in the same edge SHALL NOT be accepted; acceptance requires a later edge in IDLE.
REQ-026 Per micro-step latency SHALL be 2 enabled edges (ISSUE, FETCH), plus BWAIT duration.

Reset
REQ-027 On i_RST=1 at an edge, regardless of i_CEN, SHALL go IDLE; address=8'h00, o_MC_WORD=18'h0, o_MCROM_ADDR=8'h00, o_MCROM_READ_TICK=0, o_MC_VALID=0, o_END=0, o_END_RD4=0, o_OPCODE_REQ=1 from next clock.
REQ-028 Reset mid-sequence SHALL abandon the instruction with no o_END and no o_MC_VALID.

Configuration
REQ-029 Macro IKA87AD_MCSEQ_ABORT_EN defined: SHALL add input i_ABORT (1 bit); i_ABORT=1 with i_CEN=1 in ISSUE/FETCH/BWAIT SHALL go IDLE next edge, suppress o_MC_VALID and o_MCROM_READ_TICK on that edge, and pulse o_END with o_END_RD4=0; ignored in IDLE; i_RST has priority.
REQ-030 Macro undefined: i_ABORT port SHALL not exist; behaviour exactly per REQ-014..028.

Verification
REQ-031 Reset, i_CEN=1, entry 8'h10, ROM[10]=seq 00, ROM[11]=seq 11 -> ticks with addr 10 then 11, two o_MC_VALID pulses, o_END=1 with o_END_RD4=1, back to IDLE.
REQ-032 Entry 8'hFF, ROM[FF]=seq 00 -> next tick addr 8'h00.
REQ-033 ROM[20]=seq 01, i_BUS_ACK held low 5 edges then high -> no tick during BWAIT, tick addr 8'h21 on edge after ack.
REQ-034 i_CEN toggling 1,0,1,0 across a sequence -> tick, o_MC_VALID, o_END never high on i_CEN=0 clocks; outputs hold.
REQ-035 i_RST asserted in BWAIT -> IDLE, o_OPCODE_REQ=1, no o_END; i_OPCODE_VALID during FETCH ignored.
REQ-036 With IKA87AD_MCSEQ_ABORT_EN: i_ABORT in ISSUE -> no tick, o_END=1 with o_END_RD4=0, IDLE next edge.

Source files
------------

// File: rtl/ika87ad_mcseq_if.sv
// rtl/ika87ad_mcseq_if.sv - decoder/ROM/bus/execution signal bundle of the microcode sequencer
interface ika87ad_mcseq_if;
  logic        i_OPCODE_VALID;
  logic [7:0]  i_OPCODE_ADDR;
  logic        i_BUS_ACK;
  logic [17:0] i_MC_DATA;
  logic        o_MCROM_READ_TICK;
  logic [7:0]  o_MCROM_ADDR;
  logic [17:0] o_MC_WORD;
  logic        o_MC_VALID;
  logic        o_OPCODE_REQ;
  logic        o_END;
  logic        o_END_RD4;

  // master is the sequencer itself, slave is everything around it
  modport master (
    input  i_OPCODE_VALID, i_OPCODE_ADDR, i_BUS_ACK, i_MC_DATA,
    output o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_WORD, o_MC_VALID,
    output o_OPCODE_REQ, o_END, o_END_RD4
  );

  modport slave (
    output i_OPCODE_VALID, i_OPCODE_ADDR, i_BUS_ACK, i_MC_DATA,
    input  o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_WORD, o_MC_VALID,
    input  o_OPCODE_REQ, o_END, o_END_RD4
  );
endinterface

// File: rtl/ika87ad_mcseq.sv
// rtl/ika87ad_mcseq.sv - microcode sequencer IDLE/ISSUE/FETCH/BWAIT
// Optional abort input enabled by defining IKA87AD_MCSEQ_ABORT_EN.
module ika87ad_mcseq (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_CEN,
`ifdef IKA87AD_MCSEQ_ABORT_EN
  input  logic                  i_ABORT,
`endif
  ika87ad_mcseq_if.master       bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FETCH = 2'd2,
    S_BWAIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [17:0] word_q, word_d;
  logic        rd4_q, rd4_d;
  logic        tick_w, valid_w, end_w;
  logic        abort_w;

`ifdef IKA87AD_MCSEQ_ABORT_EN
  assign abort_w = i_ABORT;
`else
  assign abort_w = 1'b0;
`endif

  // Strobes are Mealy outputs of the enabled edge they belong to, so a
  // disabled cycle or a reset cycle can never show one.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    rd4_d   = rd4_q;
    tick_w  = 1'b0;
    valid_w = 1'b0;
    end_w   = 1'b0;
    if (i_CEN && !i_RST) begin
      if (abort_w && state_q != S_IDLE) begin
        state_d = S_IDLE;
        end_w   = 1'b1;
        rd4_d   = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.i_OPCODE_VALID) begin
              addr_d  = bus.i_OPCODE_ADDR;
              state_d = S_ISSUE;
            end
          end
          S_ISSUE: begin
            tick_w  = 1'b1;
            state_d = S_FETCH;
          end
          S_FETCH: begin
            valid_w = 1'b1;
            word_d  = bus.i_MC_DATA;
            case (bus.i_MC_DATA[1:0])
              2'b00: begin
                addr_d  = addr_q + 8'd1;
                state_d = S_ISSUE;
              end
              2'b01: begin
                addr_d  = addr_q + 8'd1;
                state_d = S_BWAIT;
              end
              default: begin
                end_w   = 1'b1;
                rd4_d   = bus.i_MC_DATA[0];
                state_d = S_IDLE;
              end
            endcase
          end
          S_BWAIT: begin
            if (bus.i_BUS_ACK) begin
              state_d = S_ISSUE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      addr_q  <= 8'h00;
      word_q  <= 18'h0;
      rd4_q   <= 1'b0;
    end else if (i_CEN) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      rd4_q   <= rd4_d;
    end
  end

  // rd4_d equals rd4_q except during an end pulse, so the qualifier
  // is valid alongside o_END and holds afterwards.
  assign bus.o_MCROM_READ_TICK = tick_w;
  assign bus.o_MCROM_ADDR      = addr_q;
  assign bus.o_MC_WORD         = word_q;
  assign bus.o_MC_VALID        = valid_w;
  assign bus.o_OPCODE_REQ      = (state_q == S_IDLE);
  assign bus.o_END             = end_w;
  assign bus.o_END_RD4         = rd4_d;

endmodule
